// File: rtl/riscv_divider_if.sv
// Request/result handshake bundle for riscv_divider.
// The slave modport is the divider side; the master modport is the requester side.
interface riscv_divider_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_dbz;
    logic             out_ovf;

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_dbz, out_ovf
    );

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_dbz, out_ovf
    );
endinterface

// File: rtl/riscv_divider.sv
// RISC-V M-extension divider (DIV/DIVU/REM/REMU): restoring radix-2, one quotient bit per cycle.
// Optional macro RISCV_DIVIDER_EARLY_OUT_EN finishes |a| < |b| requests in one cycle.
module riscv_divider #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    riscv_divider_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             signed_op, a_neg, b_neg, b_zero, ovf_req, accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] trial, diff;
    logic             q_bit;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] quo_step, rem_raw, quo_fix, rem_fix;

    always_comb begin
        signed_op = ~bus.in_op[0];
        a_neg     = signed_op & bus.in_a[WIDTH-1];
        b_neg     = signed_op & bus.in_b[WIDTH-1];
        a_mag     = a_neg ? -bus.in_a : bus.in_a;
        b_mag     = b_neg ? -bus.in_b : bus.in_b;
        b_zero    = (bus.in_b == '0);
        ovf_req   = signed_op & (bus.in_a == MOST_NEG) & (bus.in_b == '1);
        accept    = bus.in_valid & (state_q == IDLE) & ~bus.flush;

        // Shift the partial remainder left by one, pulling in the next dividend bit.
        trial    = {acc_q, quo_q[WIDTH-1]};
        diff     = trial - {2'b00, div_q};
        q_bit    = ~diff[WIDTH+1];
        acc_step = q_bit ? diff[WIDTH:0] : trial[WIDTH:0];
        quo_step = {quo_q[WIDTH-2:0], q_bit};
        rem_raw  = acc_step[WIDTH-1:0];
        quo_fix  = neg_quo_q ? -quo_step : quo_step;
        rem_fix  = neg_rem_q ? -rem_raw : rem_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        tag_d     = tag_q;
        div_d     = div_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        data_d    = data_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d  = bus.in_op[1];
                    tag_d     = bus.in_tag;
                    div_d     = b_mag;
                    acc_d     = '0;
                    quo_d     = a_mag;
                    cnt_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                    if (b_zero) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        data_d  = bus.in_op[1] ? bus.in_a : '1;
                    end else if (ovf_req) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        data_d  = bus.in_op[1] ? '0 : bus.in_a;
                    end
`ifdef RISCV_DIVIDER_EARLY_OUT_EN
                    else if (a_mag < b_mag) begin
                        state_d = DONE;
                        data_d  = bus.in_op[1] ? bus.in_a : '0;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    data_d  = is_rem_q ? rem_fix : quo_fix;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over every transition; a coincident out handshake is simply the last consume.
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            tag_q     <= '0;
            div_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            data_q    <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            tag_q     <= tag_d;
            div_q     <= div_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            data_q    <= data_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_dbz   = dbz_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: doc/riscv_divider.md
RISCV_DIVIDER -- requirements
Module: riscv_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal values 8, 16, 32, 64.
REQ-002 Parameter TAG_W, default 6: width of the opaque tag carried from request to result.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous kill of any in-flight or pending operation.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when in_valid and in_ready are both high at a rising edge.
REQ-008 in_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-009 in_a  input  WIDTH  dividend.
REQ-010 in_b  input  WIDTH  divisor.
REQ-011 in_tag  input  TAG_W  request tag.
REQ-012 out_valid  output  1  result present; held until consumed.
REQ-013 out_ready  input  1  result consumed when out_valid and out_ready are both high at a rising edge.
REQ-014 out_data  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-015 out_tag  output  TAG_W  tag of the accepted request.
REQ-016 out_dbz  output  1  divisor was zero.
REQ-017 out_ovf  output  1  signed overflow: dividend is the most negative value, divisor is -1, op is DIV or REM.

Function
REQ-018 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-019 in_ready SHALL be high only in IDLE; while in IDLE, out_valid SHALL be low.
REQ-020 On accept, the block SHALL register op, tag and operand magnitudes, taking the two's-complement of negative operands for DIV/REM only, and SHALL register the result signs: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-021 Divide by zero on accept SHALL go IDLE->DONE with out_dbz=1; result: quotient all ones, remainder = in_a unmodified.
REQ-022 Signed overflow on accept SHALL go IDLE->DONE with out_ovf=1; result: quotient = in_a, remainder = 0.
REQ-023 Otherwise the block SHALL enter CALC and run a restoring radix-2 iteration, one quotient bit per cycle, with a WIDTH+1-bit accumulator.
REQ-024 CALC SHALL last exactly WIDTH cycles, counted by a $clog2(WIDTH)-bit counter, then go to DONE, applying sign correction to the quotient and remainder.
REQ-025 Normal latency: out_valid SHALL rise WIDTH+1 cycles after the accept edge; for dbz/ovf it SHALL rise 1 cycle after.
REQ-026 In DONE, out_valid SHALL be 1, and out_data/out_tag/out_dbz/out_ovf SHALL be stable until the handshake; the handshake SHALL return the FSM to IDLE.
REQ-027 A new request SHALL NOT be accepted in the consuming cycle (in_ready low); the earliest next accept is one cycle later.
REQ-028 flush SHALL force IDLE on the next edge from any state, discarding the result; if flush coincides with an in_valid/in_ready handshake, the request SHALL be dropped.
REQ-029 If flush coincides with an out handshake, the result SHALL count as consumed once; no duplicate result SHALL appear.
REQ-030 Remainder sign SHALL follow the dividend and quotient SHALL truncate toward zero, per the RISC-V M extension.

Reset
REQ-031 While rst_n=0 at an edge: state=IDLE, counter=0, out_valid=0, out_data=0, out_tag=0, out_dbz=0, out_ovf=0, accumulator and quotient registers=0.
REQ-032 Reset SHALL take priority over flush and all handshakes; reset mid-CALC SHALL abandon the operation with no result emitted.

Configuration
REQ-033 Macro RISCV_DIVIDER_EARLY_OUT_EN: when defined, a non-dbz/non-ovf request with |a| < |b| SHALL go IDLE->DONE with quotient 0 and remainder = in_a, at latency 1.
REQ-034 Without RISCV_DIVIDER_EARLY_OUT_EN, such requests SHALL take the full WIDTH+1 latency with identical results.

Verification (WIDTH=32)
REQ-035 DIV a=-7 (0xFFFFFFF9), b=2 -> out_data=0xFFFFFFFD (-3), out_valid 33 cycles after accept; REM with the same operands -> 0xFFFFFFFF (-1).
REQ-036 DIVU a=0x80000000, b=0 -> out_dbz=1, out_data=0xFFFFFFFF after 1 cycle; REMU with the same operands -> 0x80000000.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> out_ovf=1, out_data=0x80000000; REM with the same operands -> 0.
REQ-038 DIVU 100/7, tag=0x2A, out_ready held low for 5 cycles -> out_data=14 and out_tag=0x2A stable throughout; in_ready low until the cycle after the consume.
REQ-039 flush asserted at CALC cycle 10 -> in_ready high next cycle, no out_valid; the next request DIVU 9/3 -> 3.
REQ-040 REMU 3/10 -> 3 at latency 1 with RISCV_DIVIDER_EARLY_OUT_EN defined, latency 33 without it.
